// File: rtl/ir_freq_classifier.sv
// rtl/ir_freq_classifier.sv - IR receiver period measurement, averaging, band classification and lock
module ir_freq_classifier #(
    parameter int CNT_W       = 20,
    parameter int AVG_LOG2    = 2,
    parameter int GLITCH_CYC  = 16,
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int LOCK_N      = 3,
    parameter int B1_LO       = 475000,
    parameter int B1_HI       = 525000,
    parameter int B2_LO       = 95000,
    parameter int B2_HI       = 105000,
    parameter int B3_LO       = 19000,
    parameter int B3_HI       = 21000,
    parameter int B4_LO       = 13700,
    parameter int B4_HI       = 14900
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             blinky,
    output logic [CNT_W-1:0] clk_count,
    output logic             done,
    output logic [2:0]       decision,
    output logic             locked
);

    localparam int SUM_W = CNT_W + AVG_LOG2;
    localparam int GC_W  = $clog2(GLITCH_CYC + 1);
    localparam int PC_W  = AVG_LOG2 + 1;
    localparam int RUN_W = $clog2(LOCK_N + 1);

    localparam logic [CNT_W-1:0] TIMEOUT_V   = CNT_W'(TIMEOUT_CYC);
    localparam logic [GC_W-1:0]  GLITCH_LAST = GC_W'(GLITCH_CYC - 1);
    localparam logic [PC_W-1:0]  WIN_LAST    = PC_W'((1 << AVG_LOG2) - 1);
    localparam logic [RUN_W-1:0] LOCK_V      = RUN_W'(LOCK_N);
    localparam logic [2:0]       DEC_NONE    = 3'd0;
    localparam logic [2:0]       DEC_OOB     = 3'd7;

    typedef enum logic {
        S_IDLE,
        S_MEASURE
    } state_t;

    // Input path
    logic             sync_1;
    logic             sync_2;
    logic             filt;
    logic [GC_W-1:0]  glitch_cnt;
    logic             edge_pulse;

    // Period measurement
    logic [CNT_W-1:0] period_cnt;

    // Window accumulation
    state_t           state;
    state_t           state_nx;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] sum_nx;
    logic [PC_W-1:0]  per_cnt;
    logic [PC_W-1:0]  per_cnt_nx;
    logic             win_full;
    logic             timeout_hit;

    // Averaged result waiting for classification
    logic             avg_valid;
    logic [CNT_W-1:0] avg_q;

    // Classification and lock tracking
    logic [2:0]       band_dec;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_nx;

    function automatic logic in_range(input logic [CNT_W-1:0] v, input int lo, input int hi);
        return (v >= CNT_W'(lo)) && (v <= CNT_W'(hi));
    endfunction

    // Two-flop synchroniser for the asynchronous receiver line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= blinky;
            sync_2 <= sync_1;
        end
    end

    // Glitch filter: accept a new level only after it persists GLITCH_CYC cycles; flag filtered rises
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt       <= 1'b0;
            glitch_cnt <= '0;
            edge_pulse <= 1'b0;
        end else begin
            edge_pulse <= 1'b0;
            if (sync_2 != filt) begin
                if (glitch_cnt == GLITCH_LAST) begin
                    filt       <= sync_2;
                    glitch_cnt <= '0;
                    edge_pulse <= sync_2;
                end else begin
                    glitch_cnt <= glitch_cnt + GC_W'(1);
                end
            end else begin
                glitch_cnt <= '0;
            end
        end
    end

    // Period counter: restarts at 1 on each edge so its value at the next edge is the exact period
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_cnt <= '0;
        end else if (edge_pulse) begin
            period_cnt <= CNT_W'(1);
        end else if (period_cnt != TIMEOUT_V) begin
            period_cnt <= period_cnt + CNT_W'(1);
        end
    end

    // Measurement FSM: arming in IDLE, window accumulation and timeout detection in MEASURE
    always_comb begin
        state_nx    = state;
        sum_nx      = sum;
        per_cnt_nx  = per_cnt;
        win_full    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (edge_pulse) begin
                    state_nx   = S_MEASURE;
                    sum_nx     = '0;
                    per_cnt_nx = '0;
                end
            end
            S_MEASURE: begin
                if (edge_pulse) begin
                    sum_nx = sum + SUM_W'(period_cnt);
                    if (per_cnt == WIN_LAST) begin
                        win_full   = 1'b1;
                        per_cnt_nx = '0;
                    end else begin
                        per_cnt_nx = per_cnt + PC_W'(1);
                    end
                end else if (period_cnt == TIMEOUT_V) begin
                    timeout_hit = 1'b1;
                    state_nx    = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // FSM state, running sum and the truncated average handed to the classifier
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            sum       <= '0;
            per_cnt   <= '0;
            avg_valid <= 1'b0;
            avg_q     <= '0;
        end else begin
            state     <= state_nx;
            sum       <= win_full ? '0 : sum_nx;
            per_cnt   <= per_cnt_nx;
            avg_valid <= win_full;
            if (win_full) begin
                avg_q <= sum_nx[SUM_W-1:AVG_LOG2];
            end
        end
    end

    // Band lookup: first matching band wins, so overlaps resolve to the lower index
    always_comb begin
        band_dec = DEC_OOB;
        if (in_range(avg_q, B1_LO, B1_HI)) begin
            band_dec = 3'd1;
        end else if (in_range(avg_q, B2_LO, B2_HI)) begin
            band_dec = 3'd2;
        end else if (in_range(avg_q, B3_LO, B3_HI)) begin
            band_dec = 3'd3;
        end else if (in_range(avg_q, B4_LO, B4_HI)) begin
            band_dec = 3'd4;
        end
    end

    // Run length of identical in-band results; saturates at LOCK_N
    always_comb begin
        run_nx = '0;
        if (band_dec != DEC_OOB) begin
            if ((band_dec == decision) && (run_cnt != '0)) begin
                run_nx = (run_cnt == LOCK_V) ? run_cnt : run_cnt + RUN_W'(1);
            end else begin
                run_nx = RUN_W'(1);
            end
        end
    end

    // Result publication: timeout clears everything, a finished window publishes its classification
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_count <= '0;
            done      <= 1'b0;
            decision  <= DEC_NONE;
            locked    <= 1'b0;
            run_cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (timeout_hit) begin
                done      <= 1'b1;
                clk_count <= '0;
                decision  <= DEC_NONE;
                locked    <= 1'b0;
                run_cnt   <= '0;
            end else if (avg_valid) begin
                done      <= 1'b1;
                clk_count <= avg_q;
                decision  <= band_dec;
                locked    <= (run_nx >= LOCK_V);
                run_cnt   <= run_nx;
            end
        end
    end

endmodule

// File: doc/ir_freq_classifier.md
# ir_freq_classifier

Parametrised successor to the single-rate IR beacon detector. Synchronises and de-glitches one IR receiver line (`blinky`) and measures its period in `clk` cycles. Averages 2^AVG_LOG2 consecutive periods and classifies the average into one of four programmable frequency bands. Publishes each result with a one-cycle `done` strobe, and raises `locked` once LOCK_N consecutive results agree. Sits between the IR receiver pin and the beacon-tracking logic.

## Interface
Parameters:
- CNT_W, 20: width of period counter and `clk_count`.
- AVG_LOG2, 2: log2 of the number of periods averaged per result (default 4 periods).
- GLITCH_CYC, 16: cycles a new input level must persist before it is accepted.
- TIMEOUT_CYC, 1_000_000: cycles without a rising edge before "no signal"; must be ≤ 2^CNT_W−1.
- LOCK_N, 3: number of consecutive identical in-band results required for `locked`.
- B1_LO/B1_HI, 475000/525000: band 1 inclusive bounds in cycles (200 Hz at 100 MHz).
- B2_LO/B2_HI, 95000/105000: band 2 (1 kHz).
- B3_LO/B3_HI, 19000/21000: band 3 (5 kHz).
- B4_LO/B4_HI, 13700/14900: band 4 (7 kHz).

Ports:
- clk, in, 1: single clock, 100 MHz nominal.
- rst_n, in, 1: synchronous, active-low reset.
- blinky, in, 1: asynchronous IR receiver output.
- clk_count, out, CNT_W: last averaged period in cycles.
- done, out, 1: one-cycle strobe when a new result is published.
- decision, out, 3: 0 = no signal, 1–4 = band 1–4, 7 = out of band; 5 and 6 are never produced.
- locked, out, 1: stable classification flag.

## Operation
- Input path:
  - Two-flop synchroniser feeds the glitch filter.
  - The filter output changes only after the synchronised input differs from it for GLITCH_CYC consecutive cycles.
  - A filtered 0→1 transition produces a one-cycle `edge` pulse.
- Period counter:
  - Loads 1 on `edge`, otherwise increments and saturates at TIMEOUT_CYC.
  - On `edge`, the captured period equals the counter value, i.e. the exact number of cycles between edges.
- States:
  - IDLE: entered from reset and after a timeout. The first `edge` only arms the counter; go to MEASURE with sum = 0 and periods = 0.
  - MEASURE: each `edge` adds the captured period to sum (CNT_W+AVG_LOG2 bits, cannot overflow) and increments the period count.
    - When 2^AVG_LOG2 periods are summed: avg = sum >> AVG_LOG2 (truncating), result is published, sum and period count clear, stay in MEASURE.
    - Windows are non-overlapping.
  - Timeout: in MEASURE, counter reaches TIMEOUT_CYC with no `edge` that cycle. Publish clk_count = 0, decision = 0, locked = 0, pulse `done` once, go to IDLE.
    - In IDLE, no further timeout strobes are issued.
    - An `edge` in the same cycle the counter reaches TIMEOUT_CYC is a valid capture of period TIMEOUT_CYC; no timeout.
- Classification:
  - avg is tested against B1..B4 in order, inclusive bounds; first match wins, so overlapping bands resolve to the lower index.
  - No match gives decision 7.
- Lock:
  - A run counter tracks consecutive published results whose decision equals the previous one and lies in 1–4.
  - `locked` = 1 once the run reaches LOCK_N.
  - A differing decision, a decision of 7, or a timeout resets the run; the new result starts the run at 1 if it is in 1–4, else at 0.
- `clk_count`, `decision` and `locked` hold between `done` strobes.

## Timing
- Reset values: clk_count = 0, done = 0, decision = 0, locked = 0. State is IDLE; synchroniser, filter, counter, sum and run counter are all cleared.
- Reset mid-window discards the partial window; the first edge after release only arms.
- Input latency: a clean `blinky` rise produces `edge` 2 + GLITCH_CYC cycles later.
- Result latency: `done` is high exactly 2 cycles after the `edge` that completes a window. `clk_count`, `decision` and `locked` update in that same cycle.
- Timeout latency: `done` is high 1 cycle after the counter reaches TIMEOUT_CYC.
- `done` is never high on two consecutive cycles.
- First result after arming arrives 2^AVG_LOG2 periods + 2 cycles after the arming edge.

## Test plan
- Reset: hold rst_n low 5 cycles while blinky toggles every 3 cycles → all outputs 0 and no `done` during reset. After release, the first edge produces no `done`.
- 7 kHz: blinky half-period 7200 cycles (period 14400) → every 57600 cycles: `done`, clk_count = 14400, decision = 4. `locked` rises with the 3rd result.
- Band change: 1 kHz (100000) for 4 results, then 5 kHz (20000).
  - 1 kHz results: decision = 2, locked = 1.
  - Window straddling the switch, e.g. periods 100000,20000,20000,20000 → avg 40000 → decision 7, locked = 0.
  - locked returns 1 on the 3rd clean result, clk_count = 20000, decision = 3.
- Glitch rejection: 5 kHz signal with 8-cycle low and high spikes injected mid-phase → clk_count stays 20000, decision 3, locked unaffected. A 20-cycle spike is accepted as an edge and breaks the result.
- Timeout: stop blinky low after a locked 7 kHz run → exactly TIMEOUT_CYC + 1 cycles after the last `edge`, one `done` with clk_count = 0, decision = 0, locked = 0. No further strobes; the next edge only arms.
- Out of band and reset mid-window: period 33334 → decision 7, locked stays 0. Assert rst_n low for 1 cycle after 2 periods → outputs 0, next result needs an arming edge plus 4 full periods.
